// File: rtl/spi_wrapper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_wrapper_pkg
// Purpose  : Shared types and constants for the SPI wrapper front end.
// Revision : 1.0 - initial release
// ============================================================================
package spi_wrapper_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int FRAME_W    = DATA_W_DEF + 2;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // READ_DATA owns the sub-phases WAIT_TX / SHIFT / DONE; DONE is also the
    // parking state for finished WRITE / READ_ADD frames.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4,
        ST_WAIT_TX   = 3'd5,
        ST_SHIFT     = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_miso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : spi_miso_serializer
// Purpose  : Loads a read byte and shifts it out on MISO, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module spi_miso_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_miso,
    output logic              o_last
);

    localparam int c_cnt_w = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]  r_sh;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_miso;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_miso <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_miso <= 1'b0;
        end else if (i_load) begin
            r_sh   <= i_load_data;
            r_cnt  <= c_cnt_w'(DATA_W);
            r_miso <= 1'b0;
        end else if (r_cnt != '0) begin
            r_miso <= r_sh[DATA_W-1];
            r_sh   <= {r_sh[DATA_W-2:0], 1'b0};
            r_cnt  <= r_cnt - c_cnt_w'(1);
        end else begin
            r_miso <= 1'b0;
        end
    end

    assign o_miso = r_miso;
    // High on the edge that puts the final bit onto MISO.
    assign o_last = (r_cnt == c_cnt_w'(1));

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Purpose  : SPI slave front end: MOSI frames to RAM commands, read data to MISO.
//            Optional macro SPI_SLAVE_CMD_CHECK_EN enables command/state checking.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_if
    import spi_wrapper_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              cmd_err
);

    localparam int                 c_cnt_w    = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W);

    state_t             r_state;
    logic [DATA_W:0]    r_shift;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic               r_rd_addr_seen;
    logic [DATA_W+1:0]  r_rx_data;
    logic               r_rx_valid;
    logic               r_cmd_err;

    logic [DATA_W+1:0]  w_frame;
    logic               w_cmd_ok;
    logic               w_ser_load;
    logic               w_ser_last;

    assign w_frame    = {r_shift, MOSI};
    assign w_ser_load = (r_state == ST_WAIT_TX) && tx_valid;

`ifdef SPI_SLAVE_CMD_CHECK_EN
    logic [1:0] w_cmd;
    assign w_cmd = w_frame[DATA_W+1:DATA_W];

    always_comb begin
        w_cmd_ok = 1'b1;
        case (r_state)
            ST_WRITE:     w_cmd_ok = (w_cmd == CMD_WR_ADDR) || (w_cmd == CMD_WR_DATA);
            ST_READ_ADD:  w_cmd_ok = (w_cmd == CMD_RD_ADDR);
            ST_READ_DATA: w_cmd_ok = (w_cmd == CMD_RD_DATA);
            default:      w_cmd_ok = 1'b1;
        endcase
    end
`else
    assign w_cmd_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_rd_addr_seen <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_cmd_err      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
            if (SS_n) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_CHK_CMD;
                    ST_CHK_CMD: begin
                        r_shift   <= {{DATA_W{1'b0}}, MOSI};
                        r_bit_cnt <= '0;
                        if (!MOSI)               r_state <= ST_WRITE;
                        else if (r_rd_addr_seen) r_state <= ST_READ_DATA;
                        else                     r_state <= ST_READ_ADD;
                    end
                    ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                        r_shift   <= w_frame[DATA_W:0];
                        r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt <= '0;
                            if (w_cmd_ok) begin
                                r_rx_data  <= w_frame;
                                r_rx_valid <= 1'b1;
                                if (r_state == ST_READ_DATA) begin
                                    r_state <= ST_WAIT_TX;
                                end else begin
                                    r_state <= ST_DONE;
                                    if (r_state == ST_READ_ADD) r_rd_addr_seen <= 1'b1;
                                end
                            end else begin
                                r_cmd_err <= 1'b1;
                                r_state   <= ST_DONE;
                            end
                        end
                    end
                    ST_WAIT_TX: if (tx_valid) r_state <= ST_SHIFT;
                    ST_SHIFT: begin
                        if (w_ser_last) begin
                            r_rd_addr_seen <= 1'b0;
                            r_state        <= ST_DONE;
                        end
                    end
                    ST_DONE: r_state <= ST_DONE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    spi_miso_serializer #(
        .DATA_W (DATA_W)
    ) u_miso_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (SS_n),
        .i_load      (w_ser_load),
        .i_load_data (tx_data),
        .o_miso      (MISO),
        .o_last      (w_ser_last)
    );

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign cmd_err  = r_cmd_err;

endmodule
`default_nettype wire
